// File: rtl/cpu_run_ctrl_if.sv
// Debug read channel between the debug requester (master) and cpu_run_ctrl (slave).
// The requester holds dbg_req until it sees the one-cycle dbg_ack pulse.
interface cpu_run_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              dbg_req;
  logic              dbg_sel;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  modport master (
    output dbg_req,
    output dbg_sel,
    output dbg_addr,
    input  dbg_rdata,
    input  dbg_ack
  );

  modport slave (
    input  dbg_req,
    input  dbg_sel,
    input  dbg_addr,
    output dbg_rdata,
    output dbg_ack
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the multicycle CPU: gates the datapath clock enable
// at instruction boundaries and, while halted, serves debug reads of memory and register file.
module cpu_run_ctrl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RUN_ON_RESET = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              brk_en_i,
  input  logic [31:0]       brk_addr_i,
  input  logic [31:0]       pc_i,
  input  logic              instr_done_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              cpu_en_o,
  output logic              dbg_mem_sel_o,
  output logic [ADDR_W-1:0] dbg_mem_addr_o,
  output logic [4:0]        dbg_rf_addr_o,
  output logic              halted_o,
  output logic [31:0]       instr_count_o,
  cpu_run_ctrl_if.slave     dbg
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DBG  = 2'd3
  } state_e;

  localparam state_e RESET_STATE = (RUN_ON_RESET != 0) ? S_RUN : S_HALT;

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic              rearm_q, rearm_d;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic [31:0]       count_q;

  logic              cpu_en_s;
  logic              count_inc_s;
  logic              capture_s;
  logic              boundary_s;
  logic              brk_hit_s;
  logic              dbg_active_s;

  // The first fetch after leaving HALT is the resume point, not a retirement.
  assign boundary_s   = instr_done_i & ~first_q;
  assign brk_hit_s    = brk_en_i & (pc_i == brk_addr_i);
  assign dbg_active_s = (state_q == S_DBG);

  // Next-state, clock-enable and bookkeeping decode.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    rearm_d     = rearm_q;
    cpu_en_s    = 1'b0;
    count_inc_s = 1'b0;
    capture_s   = 1'b0;
    case (state_q)
      S_HALT: begin
        if (dbg.dbg_req && !rearm_q) begin
          state_d   = S_DBG;
          capture_s = 1'b1;
        end else if (step_i) begin
          state_d = S_STEP;
          first_d = 1'b1;
        end else if (run_i) begin
          state_d = S_RUN;
          first_d = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end
      S_RUN: begin
        // A stop cycle withholds cpu_en so the pending fetch never executes.
        cpu_en_s    = ~(boundary_s & (~run_i | brk_hit_s));
        count_inc_s = boundary_s;
        state_d     = cpu_en_s ? S_RUN : S_HALT;
      end
      S_STEP: begin
        cpu_en_s    = ~boundary_s;
        count_inc_s = boundary_s;
        state_d     = boundary_s ? S_HALT : S_STEP;
      end
      S_DBG: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    first_d = (cpu_en_s & instr_done_i) ? 1'b0 : first_d;
    // A held request must drop for a cycle before it can start another access.
    rearm_d = capture_s ? 1'b1 : (dbg.dbg_req ? rearm_q : 1'b0);
  end

  // State, debug capture and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RESET_STATE;
      first_q <= 1'b1;
      rearm_q <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      rearm_q <= rearm_d;
      if (capture_s) begin
        sel_q  <= dbg.dbg_sel;
        addr_q <= dbg.dbg_addr;
      end
      if (dbg_active_s) begin
        rdata_q <= sel_q ? rf_rdata_i : mem_rdata_i;
      end
      ack_q   <= dbg_active_s;
      count_q <= count_q + {31'd0, count_inc_s};
    end
  end

  assign cpu_en_o       = cpu_en_s;
  assign halted_o       = (state_q == S_HALT);
  assign instr_count_o  = count_q;
  assign dbg_mem_sel_o  = dbg_active_s & ~sel_q;
  assign dbg_mem_addr_o = dbg_active_s ? addr_q : '0;
  assign dbg_rf_addr_o  = dbg_active_s ? addr_q[4:0] : 5'd0;
  assign dbg.dbg_rdata  = rdata_q;
  assign dbg.dbg_ack    = ack_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed + randomized bench for cpu_run_ctrl against a small multicycle CPU model
// (per-instruction cycle counts) and memory/register-file arrays kept in the bench.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic        brk_en;
  logic [31:0] brk_addr;
  logic        instr_done;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rdata;
  logic        cpu_en;
  logic        dbg_mem_sel;
  logic [8:0]  dbg_mem_addr;
  logic [4:0]  dbg_rf_addr;
  logic        halted;
  logic [31:0] instr_count;

  logic [31:0] mem [0:511];
  logic [31:0] rf  [0:31];

  // CPU model: pc, cycle within the instruction, instructions retired
  logic [31:0] pc_m;
  int unsigned phase_m;
  logic [31:0] retired_m;
  logic [31:0] cnt_base;

  int unsigned n_assert;
  int unsigned n_fail;
  int unsigned viol;
  int unsigned ack_total;
  int unsigned memsel_total;

  cpu_run_ctrl_if #(.ADDR_W(9), .DATA_W(32)) dif ();

  cpu_run_ctrl #(.ADDR_W(9), .DATA_W(32), .RUN_ON_RESET(0)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .run_i          (run),
    .step_i         (step),
    .brk_en_i       (brk_en),
    .brk_addr_i     (brk_addr),
    .pc_i           (pc_m),
    .instr_done_i   (instr_done),
    .mem_rdata_i    (mem_rdata),
    .rf_rdata_i     (rf_rdata),
    .cpu_en_o       (cpu_en),
    .dbg_mem_sel_o  (dbg_mem_sel),
    .dbg_mem_addr_o (dbg_mem_addr),
    .dbg_rf_addr_o  (dbg_rf_addr),
    .halted_o       (halted),
    .instr_count_o  (instr_count),
    .dbg            (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program: five straight-line instructions, the one at 0x14 jumps back to 0; 0x08 is a 5-cycle lw.
  function automatic int unsigned ilen(input logic [31:0] p);
    case (p)
      32'h0:   return 4;
      32'h4:   return 3;
      32'h8:   return 5;
      32'hC:   return 4;
      32'h10:  return 3;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] npc(input logic [31:0] p);
    return (p == 32'h14) ? 32'h0 : p + 32'd4;
  endfunction

  assign instr_done = (phase_m == 0);
  assign mem_rdata  = mem[dbg_mem_sel ? dbg_mem_addr : pc_m[10:2]];
  assign rf_rdata   = rf[dbg_rf_addr];

  always @(posedge clk) begin
    if (reset) begin
      pc_m      <= 32'h0;
      phase_m   <= 0;
      retired_m <= 32'h0;
    end else if (cpu_en) begin
      if (phase_m == ilen(pc_m) - 1) begin
        phase_m   <= 0;
        pc_m      <= npc(pc_m);
        retired_m <= retired_m + 32'd1;
      end else begin
        phase_m <= phase_m + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (halted && cpu_en)      viol <= viol + 1;
      if (dbg_mem_sel && cpu_en) viol <= viol + 1;
      if (dif.dbg_ack)           ack_total <= ack_total + 1;
      if (dbg_mem_sel)           memsel_total <= memsel_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_halt_reached"}, 32'(halted), 32'd1);
  endtask

  task automatic run_to_brk(input logic [31:0] bpc, input string tag, output logic [31:0] delta);
    int n;
    logic [31:0] r0;
    brk_addr = bpc;
    brk_en   = 1'b1;
    run      = 1'b1;
    r0       = retired_m;
    n        = 0;
    while (!(phase_m == 0 && pc_m == bpc && retired_m != r0) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 32'(n < 300), 32'd1);
    chk({tag, "_stop_cpu_en"}, 32'(cpu_en), 32'd0);
    run = 1'b0;
    tick();
    chk({tag, "_halted"}, 32'(halted), 32'd1);
    chk({tag, "_pc"}, pc_m, bpc);
    chk({tag, "_count"}, instr_count, retired_m + cnt_base);
    delta = retired_m - r0;
  endtask

  task automatic do_step(input string tag);
    logic [31:0] p0;
    logic [31:0] r0;
    p0   = pc_m;
    r0   = retired_m;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_halt(50, tag);
    chk({tag, "_pc"}, pc_m, npc(p0));
    chk({tag, "_count"}, instr_count, r0 + 32'd1 + cnt_base);
  endtask

  task automatic dbg_read(input logic sel, input logic [8:0] addr, input logic [31:0] exp, input string tag);
    int lat;
    int unsigned ms0;
    int unsigned ack0;
    ms0 = memsel_total;
    ack0 = ack_total;
    dif.dbg_sel  = sel;
    dif.dbg_addr = addr;
    dif.dbg_req  = 1'b1;
    lat = 0;
    while (!dif.dbg_ack && lat < 8) begin
      tick();
      lat++;
      if (lat == 1 && sel)  chk({tag, "_rf_addr"}, 32'(dbg_rf_addr), 32'(addr[4:0]));
      if (lat == 1 && !sel) chk({tag, "_mem_addr"}, 32'(dbg_mem_addr), 32'(addr));
      chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, dif.dbg_rdata, exp);
    tick();
    chk({tag, "_ack_width"}, 32'(dif.dbg_ack), 32'd0);
    dif.dbg_req = 1'b0;
    repeat (3) tick();
    chk({tag, "_ack_once"}, 32'(ack_total - ack0), 32'd1);
    chk({tag, "_memsel_cycles"}, 32'(memsel_total - ms0), sel ? 32'd0 : 32'd1);
    chk({tag, "_idle_addr"}, 32'(dbg_mem_addr), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] data;
    logic [8:0]  a;
    logic        s;
    int          n;
    int unsigned tphase;
    int unsigned ack0;

    n_assert = 0;  n_fail = 0;  viol = 0;  ack_total = 0;  memsel_total = 0;
    cnt_base = 32'd0;
    for (int i = 0; i < 512; i++) mem[i] = 32'(i) * 32'h0101_0101;
    for (int i = 0; i < 32; i++)  rf[i]  = 32'h5A00_0000 + 32'(i);
    reset = 1'b1;  run = 1'b0;  step = 1'b0;  brk_en = 1'b0;  brk_addr = 32'd0;
    dif.dbg_req = 1'b0;  dif.dbg_sel = 1'b0;  dif.dbg_addr = 9'd0;
    repeat (3) tick();

    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_ack", 32'(dif.dbg_ack), 32'd0);
    chk("rst_rdata", dif.dbg_rdata, 32'd0);
    chk("rst_memsel", 32'(dbg_mem_sel), 32'd0);

    // T1: free run from reset
    run = 1'b1;
    reset = 1'b0;
    chk("t1_first_cycle_en", 32'(cpu_en), 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t1_cpu_en", 32'(cpu_en), 32'd1);
      if (phase_m == 0 && retired_m != 32'd0) chk("t1_count_fetch", instr_count + 32'd1, retired_m);
      else chk("t1_count", instr_count, retired_m);
    end

    // T2: breakpoint at 0x0C, then single step
    run_to_brk(32'h0C, "t2", d);
    do_step("t2_step");
    chk("t2_step_pc_0x10", pc_m, 32'h10);

    // T3/T4: directed debug reads
    mem[3] = 32'hDEAD_BEEF;
    dbg_read(1'b0, 9'd3, 32'hDEAD_BEEF, "t3");
    rf[5] = 32'h0000_1234;
    dbg_read(1'b1, 9'd5, 32'h0000_1234, "t4");

    // Random debug reads
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom_range(0, 1));
      a = s ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
      data = $urandom;
      if (s) rf[a[4:0]] = data;
      else   mem[a] = data;
      dbg_read(s, a, data, "rnd_dbg");
    end

    // Random breakpoints, then resume from a breakpoint at the same PC (full loop of 6)
    for (int i = 0; i < 3; i++) run_to_brk(32'($urandom_range(0, 5)) * 32'd4, "rnd_brk", d);
    run_to_brk(pc_m, "resume_brk", d);
    chk("resume_brk_loop", d, 32'd6);
    brk_en = 1'b0;

    // run and step together: one instruction, one HALT cycle, then RUN again
    d = pc_m;
    run = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_halt(50, "runstep");
    chk("runstep_pc", pc_m, npc(d));
    tick();
    chk("runstep_resume_halted", 32'(halted), 32'd0);
    chk("runstep_resume_en", 32'(cpu_en), 32'd1);

    // T5: drop run in the middle of the lw; pending debug request during RUN
    tphase = $urandom_range(1, 4);
    n = 0;
    while (!(pc_m == 32'h8 && phase_m == tphase) && n < 100) begin
      tick();
      n++;
    end
    chk("t5_mid_lw", 32'(n < 100), 32'd1);
    run = 1'b0;
    a = 9'($urandom_range(0, 511));
    data = $urandom;
    mem[a] = data;
    ack0 = ack_total;
    dif.dbg_sel = 1'b0;  dif.dbg_addr = a;  dif.dbg_req = 1'b1;
    wait_halt(20, "t5");
    chk("t5_halt_pc", pc_m, 32'hC);
    chk("t5_halt_phase", 32'(phase_m), 32'd0);
    chk("t5_count", instr_count, retired_m + cnt_base);
    chk("t5_no_ack_in_run", 32'(ack_total - ack0), 32'd0);
    n = 0;
    while (!dif.dbg_ack && n < 6) begin
      tick();
      n++;
    end
    chk("t5_ack_after_halt", 32'(n), 32'd2);
    chk("t5_rdata", dif.dbg_rdata, data);
    dif.dbg_req = 1'b0;
    repeat (2) tick();

    // T6: counter wrap, then reset in the middle of a debug access
    force dut.count_q = 32'hFFFF_FFFF;
    repeat (2) tick();
    release dut.count_q;
    tick();
    chk("t6_preload", instr_count, 32'hFFFF_FFFF);
    cnt_base = 32'hFFFF_FFFF - retired_m;
    do_step("t6_wrap_step");
    chk("t6_wrap_zero", instr_count, 32'd0);
    ack0 = ack_total;
    dif.dbg_sel = 1'b0;  dif.dbg_addr = 9'd3;  dif.dbg_req = 1'b1;
    tick();
    chk("t6_in_dbg", 32'(dbg_mem_sel), 32'd1);
    reset = 1'b1;
    dif.dbg_req = 1'b0;
    tick();
    reset = 1'b0;
    cnt_base = 32'd0;
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_ack", 32'(dif.dbg_ack), 32'd0);
    chk("t6_cpu_en", 32'(cpu_en), 32'd0);
    chk("t6_rdata", dif.dbg_rdata, 32'd0);
    chk("t6_count", instr_count, 32'd0);
    chk("t6_memsel", 32'(dbg_mem_sel), 32'd0);
    chk("t6_mem_addr", 32'(dbg_mem_addr), 32'd0);
    repeat (3) tick();
    chk("t6_no_late_ack", 32'(ack_total - ack0), 32'd0);

    chk("no_en_while_halted_or_dbg", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
